// File: rtl/alu_pkg.sv
// Shared opcode names and flag-vector layout for the registered ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the board-level top (master) and alu_core (slave).
interface alu_if #(
  parameter int BW = 8
);
  import alu_pkg::*;

  logic              valid_i;
  logic [BW-1:0]     in_a;
  logic [BW-1:0]     in_b;
  alu_op_e           opcode;
  logic              valid_o;
  logic [BW-1:0]     out;
  logic [FLAG_W-1:0] flags;

  modport master (
    output valid_i, in_a, in_b, opcode,
    input  valid_o, out, flags
  );

  modport slave (
    input  valid_i, in_a, in_b, opcode,
    output valid_o, out, flags
  );

endinterface

// File: rtl/alu_addsub.sv
// BW-bit adder/subtractor: subtraction is a + ~b + 1; reports signed overflow.
module alu_addsub #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  input  logic          i_sub,
  output logic [BW-1:0] o_sum,
  output logic          o_ovf
);

  logic [BW-1:0] w_b;

  assign w_b   = i_sub ? ~i_b : i_b;
  assign o_sum = i_a + w_b + {{(BW-1){1'b0}}, i_sub};

  // Overflow when both addends share a sign that the sum does not.
  assign o_ovf = (i_a[BW-1] == w_b[BW-1]) && (o_sum[BW-1] != i_a[BW-1]);

endmodule

// File: rtl/alu_core.sv
// Registered ALU, one-cycle latency. Define ALU_SATURATE_EN to clamp ADD/SUB
// on signed overflow instead of wrapping.
module alu_core
  import alu_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  alu_if.slave bus
);

  localparam logic [BW-1:0] SMAX = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] SMIN = {1'b1, {(BW-1){1'b0}}};

  logic [BW-1:0]     w_sum;
  logic              w_as_ovf;
  logic              w_sub;
  logic [BW-1:0]     w_result;
  logic              w_ovf;
  logic [FLAG_W-1:0] w_flags;

  logic              r_valid;
  logic [BW-1:0]     r_out;
  logic [FLAG_W-1:0] r_flags;

  assign w_sub = (bus.opcode == OP_SUB);

  alu_addsub #(.BW(BW)) u_addsub (
    .i_a   (bus.in_a),
    .i_b   (bus.in_b),
    .i_sub (w_sub),
    .o_sum (w_sum),
    .o_ovf (w_as_ovf)
  );

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_SUB: begin
        w_result = w_sum;
        w_ovf    = w_as_ovf;
`ifdef ALU_SATURATE_EN
        // Overflow direction follows the sign of a: positive a can only overflow upward.
        if (w_as_ovf) w_result = bus.in_a[BW-1] ? SMIN : SMAX;
`endif
      end
      OP_AND: w_result = bus.in_a & bus.in_b;
      OP_OR:  w_result = bus.in_a | bus.in_b;
      OP_XOR: w_result = bus.in_a ^ bus.in_b;
      OP_NOT: w_result = ~bus.in_a;
      OP_SHL: begin
        w_result = {bus.in_a[BW-2:0], 1'b0};
        w_ovf    = bus.in_a[BW-1] ^ bus.in_a[BW-2];
      end
      OP_SHR: w_result = {1'b0, bus.in_a[BW-1:1]};
      default: begin
        w_result = '0;
        w_ovf    = 1'b0;
      end
    endcase
  end

  assign w_flags[FLAG_Z] = (w_result == '0);
  assign w_flags[FLAG_N] = w_result[BW-1];
  assign w_flags[FLAG_V] = w_ovf;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      r_valid <= bus.valid_i;
      if (bus.valid_i) begin
        r_out   <= w_result;
        r_flags <= w_flags;
      end
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.out     = r_out;
  assign bus.flags   = r_flags;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core (BW=8); expectations follow ALU_SATURATE_EN.
module tb_alu_core;
  import alu_pkg::*;

  localparam int BW = 8;

  logic clk_i;
  logic rst_ni;
  int   n_checks;
  int   n_fail;

  alu_if #(.BW(BW)) bus ();

  alu_core #(.BW(BW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one operation before the edge, then checks the registered result after it.
  task automatic run_op(input string tag, input alu_op_e op, input logic [BW-1:0] a,
                        input logic [BW-1:0] b, input logic [BW-1:0] exp_out,
                        input logic [2:0] exp_flags);
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.opcode  = op;
    bus.in_a    = a;
    bus.in_b    = b;
    @(posedge clk_i);
    #1;
    check({tag, ".out"},   32'(bus.out),     32'(exp_out));
    check({tag, ".flags"}, 32'(bus.flags),   32'(exp_flags));
    check({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_ni      = 1'b0;
    bus.valid_i = 1'b0;
    bus.opcode  = OP_ADD;
    bus.in_a    = '0;
    bus.in_b    = '0;

    #1;
    check("rst.out",   32'(bus.out),     32'h00);
    check("rst.flags", 32'(bus.flags),   32'h0);
    check("rst.valid", 32'(bus.valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

`ifdef ALU_SATURATE_EN
    run_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h7F, 3'b100);
    run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h80, 3'b110);
    run_op("add_80_80", OP_ADD, 8'h80, 8'h80, 8'h80, 3'b110);
    run_op("sub_00_80", OP_SUB, 8'h00, 8'h80, 8'h7F, 3'b100);
`else
    run_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h80, 3'b110);
    run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h7F, 3'b100);
    run_op("add_80_80", OP_ADD, 8'h80, 8'h80, 8'h00, 3'b101);
    run_op("sub_00_80", OP_SUB, 8'h00, 8'h80, 8'h80, 3'b110);
`endif
    run_op("add_12_34", OP_ADD, 8'h12, 8'h34, 8'h46, 3'b000);
    run_op("sub_05_05", OP_SUB, 8'h05, 8'h05, 8'h00, 3'b001);
    run_op("sub_03_05", OP_SUB, 8'h03, 8'h05, 8'hFE, 3'b010);
    run_op("and",       OP_AND, 8'hF0, 8'h3C, 8'h30, 3'b000);
    run_op("or",        OP_OR,  8'hF0, 8'h3C, 8'hFC, 3'b010);
    run_op("xor",       OP_XOR, 8'hF0, 8'h3C, 8'hCC, 3'b010);
    run_op("not",       OP_NOT, 8'hF0, 8'h3C, 8'h0F, 3'b000);
    run_op("shl_81",    OP_SHL, 8'h81, 8'hFF, 8'h02, 3'b100);
    run_op("shl_40",    OP_SHL, 8'h40, 8'h00, 8'h80, 3'b110);
    run_op("shr_81",    OP_SHR, 8'h81, 8'hFF, 8'h40, 3'b000);

    // valid_i dropped with toggling inputs: result held, valid_o low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      bus.valid_i = 1'b0;
      bus.opcode  = (i % 2 == 0) ? OP_NOT : OP_ADD;
      bus.in_a    = 8'(8'h11 * (i + 1));
      bus.in_b    = 8'(8'h22 * (i + 1));
      @(posedge clk_i);
      #1;
      check("idle.valid", 32'(bus.valid_o), 32'd0);
      check("idle.out",   32'(bus.out),     32'h40);
      check("idle.flags", 32'(bus.flags),   32'h0);
    end

    // Asynchronous reset in the middle of a result cycle.
    run_op("pre_rst", OP_OR, 8'h01, 8'h80, 8'h81, 3'b010);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst.out",   32'(bus.out),     32'h00);
    check("async_rst.flags", 32'(bus.flags),   32'h0);
    check("async_rst.valid", 32'(bus.valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("held_rst.valid", 32'(bus.valid_o), 32'd0);
    check("held_rst.out",   32'(bus.out),     32'h00);

    // First valid edge after release produces a result.
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op("post_rst", OP_AND, 8'hF0, 8'h3C, 8'h30, 3'b000);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_rst.drop", 32'(bus.valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
